mreq_arb: RTL and testbench

//  Shares one MREQ executor (the Wishbone master, cmd_wb) between NREQ requesters (e.g. UART and SPI command parsers).

---
 rtl/mreq_arb_pkg.sv | 5 +
 rtl/mreq_arb_rr_pick.sv | 18 +
 rtl/mreq_arb.sv | 86 ++++++++
 tb/tb_mreq_arb.sv | 115 +++++++++++
 4 files changed

// File: rtl/mreq_arb_pkg.sv
// mreq_arb_pkg: shared MREQ width and arbiter state encoding
package mreq_arb_pkg;
  localparam int MREQ_NBIT = 40;
  typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;
endpackage

// File: rtl/mreq_arb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first request after last wins
module rr_pick #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] pick
);
  always_comb begin
    pick = '0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last) + i) % N]) begin
        pick = '0;
        pick[(int'(last) + i) % N] = 1'b1;
      end
  end
endmodule

// File: rtl/mreq_arb.sv
// mreq_arb: round-robin share of one MREQ executor between NREQ requesters
// Optional MREQ_ARB_GRANT_CNT_EN adds per-port 16-bit completion counters on o_grant_cnt.
module mreq_arb
  import mreq_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NREQ-1:0]           i_req_mreq_valid,
  output logic [NREQ-1:0]           o_req_mreq_ready,
  input  logic [NREQ*MREQ_NBIT-1:0] i_req_mreq,
  input  logic [NREQ-1:0]           i_req_rx_valid,
  input  logic [NREQ*8-1:0]         i_req_rx_data,
  output logic [NREQ-1:0]           o_req_rx_ready,
  output logic [NREQ-1:0]           o_req_tx_valid,
  output logic [7:0]                o_req_tx_data,
  input  logic [NREQ-1:0]           i_req_tx_ready,
  output logic                      o_mreq_valid,
  input  logic                      i_mreq_ready,
  output logic [MREQ_NBIT-1:0]      o_mreq,
  output logic                      o_rx_valid,
  output logic [7:0]                o_rx_data,
  input  logic                      i_rx_ready,
  input  logic                      i_tx_valid,
  input  logic [7:0]                i_tx_data,
  output logic                      o_tx_ready,
  output logic [NREQ-1:0]           o_grant
`ifdef MREQ_ARB_GRANT_CNT_EN
  , output logic [NREQ*16-1:0]      o_grant_cnt
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  arb_state_t state, state_nx;
  logic [NREQ-1:0] grant_nx, pick;
  logic [IW-1:0] last, last_nx, own;
  logic busy, done;
  rr_pick #(.N(NREQ)) u_pick (.req(i_req_mreq_valid), .last(last), .pick(pick));
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= ST_IDLE;
      o_grant <= '0;
      last <= IW'(NREQ - 1);
    end else begin
      state <= state_nx;
      o_grant <= grant_nx;
      last <= last_nx;
    end
  always_comb begin
    own = '0;
    for (int i = 0; i < NREQ; i++)
      if (o_grant[i]) own = IW'(i);
  end
  assign busy = state == ST_BUSY;
  assign done = busy & i_mreq_ready;
  // Completion always drops back through idle so a stale valid is never re-accepted.
  always_comb begin
    state_nx = state;
    grant_nx = o_grant;
    last_nx = last;
    if (!busy && |i_req_mreq_valid) begin
      state_nx = ST_BUSY;
      grant_nx = pick;
    end else if (done) begin
      state_nx = ST_IDLE;
      grant_nx = '0;
      last_nx = own;
    end
  end
  assign o_mreq_valid = busy & i_req_mreq_valid[own];
  assign o_mreq = busy ? i_req_mreq[own*MREQ_NBIT +: MREQ_NBIT] : '0;
  assign o_rx_valid = busy & i_req_rx_valid[own];
  assign o_rx_data = busy ? i_req_rx_data[own*8 +: 8] : '0;
  assign o_tx_ready = busy & i_req_tx_ready[own];
  assign o_req_tx_data = busy ? i_tx_data : '0;
  assign o_req_mreq_ready = busy ? o_grant & {NREQ{i_mreq_ready}} : '0;
  assign o_req_rx_ready = busy ? o_grant & {NREQ{i_rx_ready}} : '0;
  assign o_req_tx_valid = busy ? o_grant & {NREQ{i_tx_valid}} : '0;
`ifdef MREQ_ARB_GRANT_CNT_EN
  always_ff @(posedge i_clk)
    if (i_rst) o_grant_cnt <= '0;
    else
      for (int k = 0; k < NREQ; k++)
        if (done && o_grant[k]) o_grant_cnt[k*16 +: 16] <= o_grant_cnt[k*16 +: 16] + 16'd1;
`endif
endmodule

// File: tb/tb_mreq_arb.sv
// tb_mreq_arb: randomized check of mreq_arb against a transaction-level reference model
module tb_mreq_arb;
  import mreq_arb_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0, rst;
  logic [N-1:0] req_valid, req_mready, req_rx_valid, req_rx_ready, req_tx_valid, req_tx_ready, grant;
  logic [N*MREQ_NBIT-1:0] req_mreq;
  logic [N*8-1:0] req_rx_data;
  logic [MREQ_NBIT-1:0] mreq_w [N];
  logic [7:0] rx_b [N];
  logic [7:0] req_tx_data, rx_data, tx_data;
  logic mvalid, mready, rx_valid, rx_ready, tx_valid, tx_ready;
  logic [MREQ_NBIT-1:0] mreq;
`ifdef MREQ_ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif
  int owner, last, n_vec, n_err;
  int cnt [N];
  always #5 clk = ~clk;
  mreq_arb #(.NREQ(N)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_mreq_valid(req_valid), .o_req_mreq_ready(req_mready), .i_req_mreq(req_mreq),
    .i_req_rx_valid(req_rx_valid), .i_req_rx_data(req_rx_data), .o_req_rx_ready(req_rx_ready),
    .o_req_tx_valid(req_tx_valid), .o_req_tx_data(req_tx_data), .i_req_tx_ready(req_tx_ready),
    .o_mreq_valid(mvalid), .i_mreq_ready(mready), .o_mreq(mreq),
    .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
    .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
    .o_grant(grant)
`ifdef MREQ_ARB_GRANT_CNT_EN
    , .o_grant_cnt(grant_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (owner %0d)", tag, got, exp, owner);
    end
  endtask
  // mode 0: quiet, mode 1: every port always requesting, mode 2: fully random incl. resets
  task automatic drive(input int mode);
    rst = (mode == 2) && ($urandom_range(99) < 2);
    for (int k = 0; k < N; k++) begin
      req_valid[k] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
      mreq_w[k] = MREQ_NBIT'({$urandom, $urandom});
      rx_b[k] = 8'($urandom);
      req_mreq[k*MREQ_NBIT +: MREQ_NBIT] = mreq_w[k];
      req_rx_data[k*8 +: 8] = rx_b[k];
      req_rx_valid[k] = 1'($urandom_range(1));
      req_tx_ready[k] = 1'($urandom_range(1));
    end
    mready = (mode != 0) && ($urandom_range(2) == 0);
    rx_ready = 1'($urandom_range(1));
    tx_valid = 1'($urandom_range(1));
    tx_data = 8'($urandom);
  endtask
  task automatic check_outputs();
    logic [N-1:0] oh;
    bit b;
    oh = '0;
    b = owner >= 0;
    if (b) oh[owner] = 1'b1;
    chk("grant", 64'(grant), 64'(oh));
    chk("mreq_valid", 64'(mvalid), 64'(b && req_valid[owner]));
    chk("mreq", 64'(mreq), b ? 64'(mreq_w[owner]) : 64'd0);
    chk("req_mreq_ready", 64'(req_mready), (b && mready) ? 64'(oh) : 64'd0);
    chk("rx_valid", 64'(rx_valid), 64'(b && req_rx_valid[owner]));
    chk("rx_data", 64'(rx_data), b ? 64'(rx_b[owner]) : 64'd0);
    chk("req_rx_ready", 64'(req_rx_ready), (b && rx_ready) ? 64'(oh) : 64'd0);
    chk("req_tx_valid", 64'(req_tx_valid), (b && tx_valid) ? 64'(oh) : 64'd0);
    chk("req_tx_data", 64'(req_tx_data), b ? 64'(tx_data) : 64'd0);
    chk("tx_ready", 64'(tx_ready), 64'(b && req_tx_ready[owner]));
`ifdef MREQ_ARB_GRANT_CNT_EN
    for (int k = 0; k < N; k++) chk("grant_cnt", 64'(grant_cnt[k*16 +: 16]), 64'(cnt[k]));
`endif
  endtask
  task automatic step();
    if (rst) begin
      owner = -1;
      last = N - 1;
      for (int k = 0; k < N; k++) cnt[k] = 0;
    end else if (owner < 0) begin
      for (int i = 1; i <= N; i++)
        if (owner < 0 && req_valid[(last + i) % N]) owner = (last + i) % N;
    end else if (mready) begin
      cnt[owner] = (cnt[owner] + 1) % 65536;
      last = owner;
      owner = -1;
    end
  endtask
  task automatic run(input int mode, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      drive(mode);
      #1;
      check_outputs();
      @(posedge clk);
      step();
    end
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    drive(0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    step();
    run(0, 10);
    run(1, 60);
    run(2, 3000);
    run(1, 40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
